sort_topk_merge: RTL
====================

// Module: sort_topk_merge
// PURPOSE
//  Final stage of the npu_core top-K sorter; sits after sort_E2.
//  - Consumes each E2 batch: 5 highest (H) and 5 lowest (L) {index,data} entries of one 32-element block, indices already global.
//  - Maintains running global top-5 max and bottom-5 min lists.
//  - On the last batch, drains the 10 results through a valid/ready stream.
// PARAMETERS
//  Data_Width   8   unsigned data field width, bits [Data_Width-1:0] of an entry
//  Index_Width  16  global index field width, bits [EW-1:Data_Width], EW=Index_Width+Data_Width
// PORTS
//  sys_clk          in   1   single clock, all logic rising-edge
//  sys_rst          in   1   asynchronous, active-high reset
//  sorter_clr       in   1   synchronous clear, same meaning as upstream stages
//  E2H_sorter_out0..4  in  EW  batch H list, out0 = largest
//  E2L_sorter_out0..4  in  EW  batch L list, out0 = smallest
//  E2_sort_en       in   1   batch valid this cycle (no backpressure upstream)
//  E2_last_sort     in   1   final batch marker; may also arrive alone
//  merge_busy       out  1   high in MERGE or DRAIN
//  merge_ovf        out  1   sticky: a batch arrived while busy and was dropped
//  res_valid        out  1   result beat valid
//  res_ready        in   1   result beat accepted when res_valid&res_ready
//  res_data         out  EW  {index,data} of the result entry
//  res_hit          out  1   1 = slot holds a real entry, 0 = empty slot
//  res_sel          out  1   0 = H list, 1 = L list
//  res_rank         out  3   0..4 position in the list
//  res_last         out  1   high on beat 9 (L rank 4)
//  batch_cnt        out  16  accepted-batch count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (sys_rst=1) and sorter_clr:
//  - State=IDLE; all list slots empty, all outputs 0, merge_ovf cleared, pending_last cleared.
//  - sorter_clr takes priority over every other event in that cycle.
//  States: IDLE, MERGE, DRAIN.
//  - IDLE + E2_sort_en: latch 10 inputs into a candidate buffer, go to MERGE.
//    - If E2_last_sort is also high, set pending_last.
//  - IDLE + E2_last_sort alone: go straight to DRAIN.
//  - MERGE: 5 cycles, k=0..4; cycle k inserts candidate H[k] into Hlist and L[k] into Llist in parallel.
//    - Insertion: find first slot that is empty or loses the compare; shift lower slots down one; slot 4 falls off.
//    - H compare: candidate data > slot data (strict). L compare: candidate data < slot data (strict).
//    - Ties keep the existing entry ahead, so the earlier index wins.
//    - Candidates with equal keys keep their batch order.
//    - At k=4: go to DRAIN if pending_last (clear it), else to IDLE.
//    - Next batch is accepted at earliest 6 cycles after the previous one.
//  - MERGE or DRAIN + E2_sort_en: batch dropped, merge_ovf<=1.
//    - An E2_last_sort arriving with a dropped batch still sets pending_last.
//    - pending_last is honoured after MERGE; it is ignored in DRAIN.
//  - DRAIN: beats 0..4 = H ranks 0..4, beats 5..9 = L ranks 0..4.
//    - res_valid registered; beat held stable until res_ready.
//    - Empty slot: res_hit=0, res_data=0.
//    - After beat 9 handshake: lists emptied, go to IDLE, res_valid=0 in the next cycle.
//  merge_ovf: cleared only by reset or sorter_clr.
//  Arithmetic: compares are unsigned on data bits only; index bits are carried untouched.
// CONFIGURATION
//  SORT_MERGE_STATS_EN defined:
//  - batch_cnt increments on each accepted batch, saturates at 16'hFFFF.
//  - Cleared at DRAIN completion, reset and sorter_clr.
//  Not defined: batch_cnt is tied to 0 and no counter logic exists.
// TESTING
//  1. Single batch, H data 90,80,70,60,50 / L data 1,2,3,4,5, last_sort=1, res_ready=1 -> 10 beats in rank order with those data, all res_hit=1, res_last on beat 9.
//  2. Two batches 8 cycles apart: batch A H=10,9,8,7,6; batch B H=12,9,5,4,3 -> H drain data 12,10,9(A idx),9(B idx),8.
//  3. Batch 3 cycles after a batch -> second batch dropped, merge_ovf=1, lists equal first batch only.
//  4. Lone E2_last_sort in IDLE after reset -> 10 beats with res_hit=0, res_data=0.
//  5. res_ready toggled 1-0-0-1 during DRAIN -> beats hold stable, none lost or duplicated.
//  6. sorter_clr pulsed mid-MERGE (k=2) and mid-DRAIN (beat 4) -> next cycle IDLE, res_valid=0, lists empty; with SORT_MERGE_STATS_EN, batch_cnt=0.

Source files
------------

// File: rtl/sort_topk_merge.sv
// Final top-K stage: folds E2 batches into running global top-5 max / bottom-5 min lists, then drains 10 results.
// Latency: a batch merges in 5 cycles after acceptance; the first result beat is valid on the cycle after MERGE ends.
// Backpressure: result beats hold until res_ready; batches arriving while busy are dropped and flagged (SORT_MERGE_STATS_EN adds batch_cnt).
module sort_topk_merge #(
    parameter int Data_Width  = 8,
    parameter int Index_Width = 16,
    localparam int EW = Index_Width + Data_Width
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          sorter_clr,
    input  logic [EW-1:0] E2H_sorter_out0,
    input  logic [EW-1:0] E2H_sorter_out1,
    input  logic [EW-1:0] E2H_sorter_out2,
    input  logic [EW-1:0] E2H_sorter_out3,
    input  logic [EW-1:0] E2H_sorter_out4,
    input  logic [EW-1:0] E2L_sorter_out0,
    input  logic [EW-1:0] E2L_sorter_out1,
    input  logic [EW-1:0] E2L_sorter_out2,
    input  logic [EW-1:0] E2L_sorter_out3,
    input  logic [EW-1:0] E2L_sorter_out4,
    input  logic          E2_sort_en,
    input  logic          E2_last_sort,
    output logic          merge_busy,
    output logic          merge_ovf,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [EW-1:0] res_data,
    output logic          res_hit,
    output logic          res_sel,
    output logic [2:0]    res_rank,
    output logic          res_last,
    output logic [15:0]   batch_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_MERGE, ST_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [2:0]    k_q, k_d;
    logic [3:0]    beat_q, beat_d;
    logic          pending_q, pending_d;
    logic          ovf_q, ovf_d;
    logic          res_valid_q, res_valid_d;
    logic [EW-1:0] cand_h_q [5];
    logic [EW-1:0] cand_h_d [5];
    logic [EW-1:0] cand_l_q [5];
    logic [EW-1:0] cand_l_d [5];
    logic [EW-1:0] h_list_q [5];
    logic [EW-1:0] h_list_d [5];
    logic [EW-1:0] l_list_q [5];
    logic [EW-1:0] l_list_d [5];
    logic [4:0]    h_vld_q, h_vld_d;
    logic [4:0]    l_vld_q, l_vld_d;

    logic [EW-1:0] in_h [5];
    logic [EW-1:0] in_l [5];
    logic [EW-1:0] h_cand, l_cand;
    logic [4:0]    h_ins, l_ins;
    logic [EW-1:0] h_mrg [5];
    logic [EW-1:0] l_mrg [5];
    logic [4:0]    h_mrg_vld, l_mrg_vld;
    logic          drain_done;
    logic          out_sel;
    logic [2:0]    out_rank;
    logic [EW-1:0] out_entry;
    logic          out_hit;

    assign in_h[0] = E2H_sorter_out0;
    assign in_h[1] = E2H_sorter_out1;
    assign in_h[2] = E2H_sorter_out2;
    assign in_h[3] = E2H_sorter_out3;
    assign in_h[4] = E2H_sorter_out4;
    assign in_l[0] = E2L_sorter_out0;
    assign in_l[1] = E2L_sorter_out1;
    assign in_l[2] = E2L_sorter_out2;
    assign in_l[3] = E2L_sorter_out3;
    assign in_l[4] = E2L_sorter_out4;

    assign drain_done = (state_q == ST_DRAIN) && res_valid_q && res_ready && (beat_q == 4'd9);

    // Lists stay sorted with valid slots packed at the front, so the insert mask is monotonic:
    // the first set bit is the insert point and every later slot takes its predecessor.
    always_comb begin
        h_cand = cand_h_q[k_q];
        l_cand = cand_l_q[k_q];
        for (int i = 0; i < 5; i++) begin
            h_ins[i] = !h_vld_q[i] || (h_cand[Data_Width-1:0] > h_list_q[i][Data_Width-1:0]);
            l_ins[i] = !l_vld_q[i] || (l_cand[Data_Width-1:0] < l_list_q[i][Data_Width-1:0]);
        end
        h_mrg[0]     = h_ins[0] ? h_cand : h_list_q[0];
        h_mrg_vld[0] = h_ins[0] | h_vld_q[0];
        l_mrg[0]     = l_ins[0] ? l_cand : l_list_q[0];
        l_mrg_vld[0] = l_ins[0] | l_vld_q[0];
        for (int i = 1; i < 5; i++) begin
            h_mrg[i]     = !h_ins[i] ? h_list_q[i] : (h_ins[i-1] ? h_list_q[i-1] : h_cand);
            h_mrg_vld[i] = !h_ins[i] ? h_vld_q[i]  : (h_ins[i-1] ? h_vld_q[i-1]  : 1'b1);
            l_mrg[i]     = !l_ins[i] ? l_list_q[i] : (l_ins[i-1] ? l_list_q[i-1] : l_cand);
            l_mrg_vld[i] = !l_ins[i] ? l_vld_q[i]  : (l_ins[i-1] ? l_vld_q[i-1]  : 1'b1);
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        beat_d      = beat_q;
        pending_d   = pending_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        h_vld_d     = h_vld_q;
        l_vld_d     = l_vld_q;
        for (int i = 0; i < 5; i++) begin
            cand_h_d[i] = cand_h_q[i];
            cand_l_d[i] = cand_l_q[i];
            h_list_d[i] = h_list_q[i];
            l_list_d[i] = l_list_q[i];
        end

        if (sorter_clr) begin
            state_d     = ST_IDLE;
            k_d         = 3'd0;
            beat_d      = 4'd0;
            pending_d   = 1'b0;
            ovf_d       = 1'b0;
            res_valid_d = 1'b0;
            h_vld_d     = 5'd0;
            l_vld_d     = 5'd0;
            for (int i = 0; i < 5; i++) begin
                h_list_d[i] = '0;
                l_list_d[i] = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (E2_sort_en) begin
                        for (int i = 0; i < 5; i++) begin
                            cand_h_d[i] = in_h[i];
                            cand_l_d[i] = in_l[i];
                        end
                        k_d       = 3'd0;
                        pending_d = E2_last_sort;
                        state_d   = ST_MERGE;
                    end else if (E2_last_sort) begin
                        beat_d      = 4'd0;
                        res_valid_d = 1'b1;
                        state_d     = ST_DRAIN;
                    end
                end
                ST_MERGE: begin
                    for (int i = 0; i < 5; i++) begin
                        h_list_d[i] = h_mrg[i];
                        l_list_d[i] = l_mrg[i];
                    end
                    h_vld_d = h_mrg_vld;
                    l_vld_d = l_mrg_vld;
                    if (E2_sort_en) begin
                        ovf_d = 1'b1;
                    end
                    if (E2_last_sort) begin
                        pending_d = 1'b1;
                    end
                    if (k_q == 3'd4) begin
                        if (pending_q || E2_last_sort) begin
                            pending_d   = 1'b0;
                            beat_d      = 4'd0;
                            res_valid_d = 1'b1;
                            state_d     = ST_DRAIN;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (E2_sort_en) begin
                        ovf_d = 1'b1;
                    end
                    if (drain_done) begin
                        beat_d      = 4'd0;
                        res_valid_d = 1'b0;
                        h_vld_d     = 5'd0;
                        l_vld_d     = 5'd0;
                        for (int i = 0; i < 5; i++) begin
                            h_list_d[i] = '0;
                            l_list_d[i] = '0;
                        end
                        state_d = ST_IDLE;
                    end else if (res_valid_q && res_ready) begin
                        beat_d = beat_q + 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            k_q         <= 3'd0;
            beat_q      <= 4'd0;
            pending_q   <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            h_vld_q     <= 5'd0;
            l_vld_q     <= 5'd0;
            for (int i = 0; i < 5; i++) begin
                cand_h_q[i] <= '0;
                cand_l_q[i] <= '0;
                h_list_q[i] <= '0;
                l_list_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            beat_q      <= beat_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            h_vld_q     <= h_vld_d;
            l_vld_q     <= l_vld_d;
            for (int i = 0; i < 5; i++) begin
                cand_h_q[i] <= cand_h_d[i];
                cand_l_q[i] <= cand_l_d[i];
                h_list_q[i] <= h_list_d[i];
                l_list_q[i] <= l_list_d[i];
            end
        end
    end

    // Beats 0..4 walk the H list, 5..9 the L list; 3-bit wrap maps 5..9 onto ranks 0..4.
    always_comb begin
        out_sel  = 1'b0;
        out_rank = beat_q[2:0];
        if (beat_q >= 4'd5) begin
            out_sel  = 1'b1;
            out_rank = beat_q[2:0] - 3'd5;
        end
        out_entry = out_sel ? l_list_q[out_rank] : h_list_q[out_rank];
        out_hit   = out_sel ? l_vld_q[out_rank]  : h_vld_q[out_rank];
    end

    assign merge_busy = (state_q != ST_IDLE);
    assign merge_ovf  = ovf_q;
    assign res_valid  = res_valid_q;
    assign res_hit    = res_valid_q & out_hit;
    assign res_data   = (res_valid_q && out_hit) ? out_entry : '0;
    assign res_sel    = res_valid_q & out_sel;
    assign res_rank   = res_valid_q ? out_rank : 3'd0;
    assign res_last   = res_valid_q && (beat_q == 4'd9);

`ifdef SORT_MERGE_STATS_EN
    logic [15:0] batch_cnt_q, batch_cnt_d;

    always_comb begin
        batch_cnt_d = batch_cnt_q;
        if (sorter_clr || drain_done) begin
            batch_cnt_d = 16'd0;
        end else if ((state_q == ST_IDLE) && E2_sort_en && (batch_cnt_q != 16'hFFFF)) begin
            batch_cnt_d = batch_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            batch_cnt_q <= 16'd0;
        end else begin
            batch_cnt_q <= batch_cnt_d;
        end
    end

    assign batch_cnt = batch_cnt_q;
`else
    assign batch_cnt = 16'd0;
`endif

endmodule
